// File: rtl/mem_inter_model.sv
`default_nettype none
// ============================================================================
// Module   : mem_inter_model
// Purpose  : Multi-channel TileLink-UL memory responder. NUM_CH independent
//            A/D channel pairs share one word-addressed backing store through
//            a round-robin arbiter. Each channel has its own request and
//            response queues. At most one store access happens per cycle.
// Ports    : clk, rstn (async, active-low)
//            out_a_*  : A-channel in (valid/opcode/size/source/address/mask/
//                       data/param), out_a_ready_i back-pressure out
//            out_d_*  : D-channel out (valid/opcode/size/source/data/param),
//                       out_d_ready_o in
//            err_o    : sticky per-channel unsupported-opcode flag
//            Channel c of every bus occupies slice [c*W +: W].
// Config   : `define MEM_INTER_LAT_EN adds a LATENCY-cycle age counter to
//            every response entry (DRAM delay model).
// Revision : 1.0 - initial release
// ============================================================================
module mem_inter_model #(
    parameter int NUM_CH      = 2,
    parameter int ADDR_BITS   = 32,
    parameter int DATA_BITS   = 64,
    parameter int SOURCE_BITS = 8,
    parameter int SIZE_BITS   = 4,
    parameter int OP_BITS     = 3,
    parameter int MEM_WORDS   = 1024,
    parameter int QDEPTH      = 4,
    parameter int LATENCY     = 8
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [NUM_CH-1:0]                 out_a_valid_o,
    output logic [NUM_CH-1:0]                 out_a_ready_i,
    input  logic [NUM_CH*OP_BITS-1:0]         out_a_opcode_o,
    input  logic [NUM_CH*SIZE_BITS-1:0]       out_a_size_o,
    input  logic [NUM_CH*SOURCE_BITS-1:0]     out_a_source_o,
    input  logic [NUM_CH*ADDR_BITS-1:0]       out_a_address_o,
    input  logic [NUM_CH*(DATA_BITS/8)-1:0]   out_a_mask_o,
    input  logic [NUM_CH*DATA_BITS-1:0]       out_a_data_o,
    input  logic [NUM_CH*3-1:0]               out_a_param_o,
    output logic [NUM_CH-1:0]                 out_d_valid_i,
    input  logic [NUM_CH-1:0]                 out_d_ready_o,
    output logic [NUM_CH*OP_BITS-1:0]         out_d_opcode_i,
    output logic [NUM_CH*SIZE_BITS-1:0]       out_d_size_i,
    output logic [NUM_CH*SOURCE_BITS-1:0]     out_d_source_i,
    output logic [NUM_CH*DATA_BITS-1:0]       out_d_data_i,
    output logic [NUM_CH*3-1:0]               out_d_param_i,
    output logic [NUM_CH-1:0]                 err_o
);

    localparam int MASK_BITS = DATA_BITS / 8;
    localparam int IDX_W     = $clog2(MEM_WORDS);
    localparam int OFF_W     = $clog2(MASK_BITS);
    localparam int QW        = $clog2(QDEPTH);
    localparam int CW        = QW + 1;
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int REQ_W     = OP_BITS + SIZE_BITS + SOURCE_BITS + 3 + IDX_W + MASK_BITS + DATA_BITS;
    localparam int RSP_W     = OP_BITS + SIZE_BITS + SOURCE_BITS + 3 + DATA_BITS;

    localparam logic [OP_BITS-1:0] c_op_putf = OP_BITS'(0);
    localparam logic [OP_BITS-1:0] c_op_putp = OP_BITS'(1);
    localparam logic [OP_BITS-1:0] c_op_get  = OP_BITS'(4);
    localparam logic [OP_BITS-1:0] c_op_ack  = OP_BITS'(0);
    localparam logic [OP_BITS-1:0] c_op_ackd = OP_BITS'(1);

    // Backing store; intentionally not reset (preloaded externally).
    logic [DATA_BITS-1:0] r_mem [MEM_WORDS];

    logic [NUM_CH*REQ_W-1:0] w_rq_head;
    logic [NUM_CH-1:0]       w_rq_nempty;
    logic [NUM_CH-1:0]       w_rs_free;
    logic [NUM_CH-1:0]       w_gnt_oh;
    logic                    w_gnt_vld;
    logic [CH_W-1:0]         w_gnt_idx;
    logic [CH_W-1:0]         w_cand;
    logic [CH_W-1:0]         r_rr;

    // ------------------------------------------------------------------
    // Round-robin arbiter: scan from r_rr, first channel with a pending
    // request and room on its response side wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        w_gnt_oh  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cand = CH_W'((int'(r_rr) + i) % NUM_CH);
            if (!w_gnt_vld && w_rq_nempty[w_cand] && w_rs_free[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
        if (w_gnt_vld) begin
            w_gnt_oh[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr <= '0;
        end else if (w_gnt_vld) begin
            r_rr <= (w_gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Store access for the granted request
    // ------------------------------------------------------------------
    logic [REQ_W-1:0]       w_g_req;
    logic [OP_BITS-1:0]     w_g_op;
    logic [SIZE_BITS-1:0]   w_g_size;
    logic [SOURCE_BITS-1:0] w_g_src;
    logic [2:0]             w_g_prm;
    logic [IDX_W-1:0]       w_g_idx;
    logic [MASK_BITS-1:0]   w_g_mask;
    logic [DATA_BITS-1:0]   w_g_data;
    logic [OP_BITS-1:0]     w_rsp_op;
    logic [DATA_BITS-1:0]   w_rsp_data;
    logic                   w_wr;
    logic                   w_bad;
    logic [RSP_W-1:0]       w_rsp;

    assign w_g_req = w_rq_head[w_gnt_idx*REQ_W +: REQ_W];
    assign {w_g_op, w_g_size, w_g_src, w_g_prm, w_g_idx, w_g_mask, w_g_data} = w_g_req;

    always_comb begin
        w_rsp_op   = c_op_ack;
        w_rsp_data = '0;
        w_wr       = 1'b0;
        w_bad      = 1'b0;
        case (w_g_op)
            c_op_get: begin
                w_rsp_op   = c_op_ackd;
                w_rsp_data = r_mem[w_g_idx];
            end
            c_op_putf, c_op_putp: w_wr = 1'b1;
            default:              w_bad = 1'b1;
        endcase
    end

    assign w_rsp = {w_rsp_op, w_g_size, w_g_src, w_g_prm, w_rsp_data};

    always_ff @(posedge clk) begin
        if (w_gnt_vld && w_wr) begin
            for (int b = 0; b < MASK_BITS; b++) begin
                if (w_g_mask[b]) begin
                    r_mem[w_g_idx][b*8 +: 8] <= w_g_data[b*8 +: 8];
                end
            end
        end
    end

`ifndef MEM_INTER_LAT_EN
    logic w_unused_lat;
    assign w_unused_lat = (LATENCY < 0);
`endif

    // ------------------------------------------------------------------
    // Per-channel request / response queues
    // ------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [REQ_W-1:0]       r_rq_mem [QDEPTH];
        logic [QW-1:0]          r_rq_wp, r_rq_rp;
        logic [CW-1:0]          r_rq_cnt, w_rq_cnt_nxt;
        logic                   r_a_rdy, w_rq_push, w_rq_pop;
        logic [REQ_W-1:0]       w_rq_in;
        logic [ADDR_BITS-1:0]   w_addr;
        logic                   w_unused_addr;
        logic [RSP_W-1:0]       r_rs_mem [QDEPTH];
        logic [QW-1:0]          r_rs_wp, r_rs_rp;
        logic [CW-1:0]          r_rs_cnt;
        logic                   w_rs_push, w_rs_pop, w_aged, w_d_vld;
        logic                   r_err;
        logic [OP_BITS-1:0]     w_h_op;
        logic [SIZE_BITS-1:0]   w_h_size;
        logic [SOURCE_BITS-1:0] w_h_src;
        logic [2:0]             w_h_prm;
        logic [DATA_BITS-1:0]   w_h_data;

        assign w_addr        = out_a_address_o[c*ADDR_BITS +: ADDR_BITS];
        // Only the word-index bits are stored; the rest are deliberately dropped.
        assign w_unused_addr = ^w_addr;
        assign w_rq_in = {out_a_opcode_o[c*OP_BITS +: OP_BITS],
                          out_a_size_o[c*SIZE_BITS +: SIZE_BITS],
                          out_a_source_o[c*SOURCE_BITS +: SOURCE_BITS],
                          out_a_param_o[c*3 +: 3],
                          w_addr[OFF_W +: IDX_W],
                          out_a_mask_o[c*MASK_BITS +: MASK_BITS],
                          out_a_data_o[c*DATA_BITS +: DATA_BITS]};

        assign w_rq_push    = out_a_valid_o[c] & r_a_rdy;
        assign w_rq_pop     = w_gnt_oh[c];
        assign w_rq_cnt_nxt = r_rq_cnt + CW'(w_rq_push) - CW'(w_rq_pop);

        // Ready is a registered "not full" computed from next occupancy so it
        // falls in the very cycle the queue fills and is 0 during reset.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_rq_wp  <= '0;
                r_rq_rp  <= '0;
                r_rq_cnt <= '0;
                r_a_rdy  <= 1'b0;
            end else begin
                if (w_rq_push) r_rq_wp <= r_rq_wp + 1'b1;
                if (w_rq_pop)  r_rq_rp <= r_rq_rp + 1'b1;
                r_rq_cnt <= w_rq_cnt_nxt;
                r_a_rdy  <= (w_rq_cnt_nxt != CW'(QDEPTH));
            end
        end

        always_ff @(posedge clk) begin
            if (w_rq_push) r_rq_mem[r_rq_wp] <= w_rq_in;
        end

        assign w_rq_head[c*REQ_W +: REQ_W] = r_rq_mem[r_rq_rp];
        assign w_rq_nempty[c]              = (r_rq_cnt != '0);

        assign w_rs_push    = w_gnt_oh[c];
        assign w_rs_pop     = w_d_vld & out_d_ready_o[c];
        // A head leaving this cycle makes room for the access granted now.
        assign w_rs_free[c] = (r_rs_cnt != CW'(QDEPTH)) | w_rs_pop;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_rs_wp  <= '0;
                r_rs_rp  <= '0;
                r_rs_cnt <= '0;
                r_err    <= 1'b0;
            end else begin
                if (w_rs_push) r_rs_wp <= r_rs_wp + 1'b1;
                if (w_rs_pop)  r_rs_rp <= r_rs_rp + 1'b1;
                r_rs_cnt <= r_rs_cnt + CW'(w_rs_push) - CW'(w_rs_pop);
                if (w_gnt_oh[c] && w_bad) r_err <= 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (w_rs_push) r_rs_mem[r_rs_wp] <= w_rsp;
        end

`ifdef MEM_INTER_LAT_EN
        localparam int LAT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
        logic [LAT_W-1:0] r_age [QDEPTH];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int e = 0; e < QDEPTH; e++) r_age[e] <= '0;
            end else begin
                for (int e = 0; e < QDEPTH; e++) begin
                    if (w_rs_push && (r_rs_wp == QW'(e))) begin
                        r_age[e] <= LAT_W'(LATENCY);
                    end else if (r_age[e] != '0) begin
                        r_age[e] <= r_age[e] - 1'b1;
                    end
                end
            end
        end

        assign w_aged = (r_age[r_rs_rp] == '0);
`else
        assign w_aged = 1'b1;
`endif

        assign w_d_vld = (r_rs_cnt != '0) & w_aged;
        assign {w_h_op, w_h_size, w_h_src, w_h_prm, w_h_data} = r_rs_mem[r_rs_rp];

        // Fields are forced to 0 whenever no beat is presented.
        assign out_d_valid_i[c]                            = w_d_vld;
        assign out_d_opcode_i[c*OP_BITS +: OP_BITS]         = w_d_vld ? w_h_op   : '0;
        assign out_d_size_i[c*SIZE_BITS +: SIZE_BITS]       = w_d_vld ? w_h_size : '0;
        assign out_d_source_i[c*SOURCE_BITS +: SOURCE_BITS] = w_d_vld ? w_h_src  : '0;
        assign out_d_param_i[c*3 +: 3]                      = w_d_vld ? w_h_prm  : '0;
        assign out_d_data_i[c*DATA_BITS +: DATA_BITS]       = w_d_vld ? w_h_data : '0;
        assign out_a_ready_i[c]                             = r_a_rdy;
        assign err_o[c]                                     = r_err;
    end : g_ch

endmodule

`default_nettype wire
